// File: rtl/dump_axis_packer_pkg.sv
// Shared constants, types and helpers for the dump AXI-Stream packer.
// Entry field offsets, beat layout and the control state encoding.
package dump_axis_packer_pkg;

    localparam int REC_WIDTH             = 97;
    localparam int RECS_PER_BEAT         = 5;
    localparam int AXIS_TDATA_WIDTH      = 512;
    localparam int STREAMING_TDEST_WIDTH = 16;
    localparam int IN_WIDTH              = 227;
    localparam int CNT_WIDTH             = 32;

    localparam int LANE0_LSB = 0;
    localparam int LANE1_LSB = 97;
    localparam int VALID_LSB = 194;

    localparam int BEAT_CNT_LSB = 509;
    localparam int BEAT_CNT_W   = 3;
    localparam int SLOTS_W      = REC_WIDTH * RECS_PER_BEAT;
    localparam int PAD_W        = BEAT_CNT_LSB - SLOTS_W;
    localparam int KEEP_W       = AXIS_TDATA_WIDTH / 8;

    localparam logic [BEAT_CNT_W-1:0] FULL_CNT = 3'd5;

    typedef logic [REC_WIDTH-1:0] rec_t;
    typedef logic [RECS_PER_BEAT-1:0][REC_WIDTH-1:0] slots_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        LAST
    } state_e;

    // Slot k sits at [97k+96:97k]; record count rides in the top bits.
    function automatic logic [AXIS_TDATA_WIDTH-1:0] pack_beat(
        input slots_t                slots,
        input logic [BEAT_CNT_W-1:0] cnt
    );
        return {cnt, {PAD_W{1'b0}}, slots};
    endfunction

endpackage

// File: rtl/dump_axis_packer_axis_out_reg.sv
// Single-entry AXI-Stream output register.
// Holds data/last while valid && !ready; reloads on the draining cycle.
module dump_axis_packer_axis_out_reg
    import dump_axis_packer_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_i,
    input  logic [AXIS_TDATA_WIDTH-1:0] data_i,
    input  logic                        last_i,
    input  logic                        tready_i,
    output logic                        valid_o,
    output logic [AXIS_TDATA_WIDTH-1:0] data_o,
    output logic                        last_o,
    output logic                        free_o
);

    logic                        valid_q;
    logic [AXIS_TDATA_WIDTH-1:0] data_q;
    logic                        last_q;

    assign free_o  = !valid_q || tready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

    // Load a new beat when free, otherwise drop valid once it transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (tready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/dump_axis_packer.sv
// Packs valid lane records from exit-queue entries into 512-bit beats,
// five records per beat, and streams them to the host with a tlast beat.
module dump_axis_packer
    import dump_axis_packer_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_dump_start,
    input  logic                             i_dump_flush,
    input  logic [STREAMING_TDEST_WIDTH-1:0] i_dest_id,
    input  logic [IN_WIDTH-1:0]              i_entry,
    input  logic                             i_entry_valid,
    output logic                             o_entry_ready,
    output logic [AXIS_TDATA_WIDTH-1:0]      o_m_axis_k2h_tdata,
    output logic [KEEP_W-1:0]                o_m_axis_k2h_tkeep,
    output logic                             o_m_axis_k2h_tvalid,
    output logic                             o_m_axis_k2h_tlast,
    output logic [STREAMING_TDEST_WIDTH-1:0] o_m_axis_k2h_tdest,
    input  logic                             i_m_axis_k2h_tready,
    output logic [CNT_WIDTH-1:0]             o_rec_count,
    output logic [CNT_WIDTH-1:0]             o_beat_count,
    output logic                             o_busy
);

    state_e                           state_q, state_d;
    slots_t                           acc_q, acc_d;
    logic [BEAT_CNT_W-1:0]            acc_cnt_q, acc_cnt_d;
    logic [STREAMING_TDEST_WIDTH-1:0] dest_q, dest_d;
    logic [CNT_WIDTH-1:0]             rec_q, rec_d;
    logic [CNT_WIDTH-1:0]             beat_q, beat_d;

    logic                             out_valid;
    logic                             out_free;
    logic                             load;
    logic [AXIS_TDATA_WIDTH-1:0]      load_data;
    logic                             load_last;

    logic                             entry_ready;
    logic                             accept;
    logic                             pend_push;
    logic [1:0]                       lane_v;
    logic [RECS_PER_BEAT:0][REC_WIDTH-1:0] merged;
    logic [BEAT_CNT_W-1:0]            merged_cnt;
    logic [BEAT_CNT_W-1:0]            n_recs;
    logic                             unused_entry_bits;

    assign unused_entry_bits = ^i_entry[IN_WIDTH-1:VALID_LSB+2];

    assign lane_v      = i_entry[VALID_LSB +: 2];
    assign pend_push   = (state_q == RUN) && (acc_cnt_q == FULL_CNT) && out_free;
    assign entry_ready = (state_q == RUN)
                       && ((acc_cnt_q <= 3'd3) || out_free);
    assign accept      = i_entry_valid && entry_ready;

    // Append the accepted lanes behind the current accumulator contents.
    // A held full beat that drains this cycle leaves an empty base.
    always_comb begin
        merged     = '0;
        merged_cnt = 3'd0;
        n_recs     = 3'd0;
        if (!pend_push) begin
            merged[RECS_PER_BEAT-1:0] = acc_q;
            merged_cnt                = acc_cnt_q;
        end
        if (accept && lane_v[0]) begin
            merged[merged_cnt] = i_entry[LANE0_LSB +: REC_WIDTH];
            merged_cnt         = merged_cnt + 3'd1;
            n_recs             = n_recs + 3'd1;
        end
        if (accept && lane_v[1]) begin
            merged[merged_cnt] = i_entry[LANE1_LSB +: REC_WIDTH];
            merged_cnt         = merged_cnt + 3'd1;
            n_recs             = n_recs + 3'd1;
        end
    end

    // Control FSM: next state, accumulator, beat loading and counters.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        dest_d    = dest_q;
        rec_d     = rec_q;
        beat_d    = beat_q + CNT_WIDTH'(out_valid && i_m_axis_k2h_tready);
        load      = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_dump_start) begin
                    state_d   = RUN;
                    dest_d    = i_dest_id;
                    acc_d     = '0;
                    acc_cnt_d = '0;
                    rec_d     = '0;
                    beat_d    = '0;
                end
            end
            RUN: begin
                if (pend_push) begin
                    load      = 1'b1;
                    load_data = pack_beat(acc_q, FULL_CNT);
                    acc_d     = merged[RECS_PER_BEAT-1:0];
                    acc_cnt_d = merged_cnt;
                end else if (merged_cnt >= FULL_CNT && out_free) begin
                    load      = 1'b1;
                    load_data = pack_beat(merged[RECS_PER_BEAT-1:0], FULL_CNT);
                    acc_d     = slots_t'({{(SLOTS_W-REC_WIDTH){1'b0}},
                                          merged[RECS_PER_BEAT]});
                    acc_cnt_d = merged_cnt - FULL_CNT;
                end else begin
                    acc_d     = merged[RECS_PER_BEAT-1:0];
                    acc_cnt_d = merged_cnt;
                end
                if (accept) begin
                    rec_d = rec_q + CNT_WIDTH'(n_recs);
                end
                if (i_dump_flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = pack_beat(acc_q, acc_cnt_q);
                    acc_d     = '0;
                    acc_cnt_d = '0;
                    if (acc_cnt_q != FULL_CNT) begin
                        load_last = 1'b1;
                        state_d   = LAST;
                    end
                end
            end
            LAST: begin
                if (out_valid && i_m_axis_k2h_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, accumulator, destination and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            acc_cnt_q <= '0;
            dest_q    <= '0;
            rec_q     <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
            dest_q    <= dest_d;
            rec_q     <= rec_d;
            beat_q    <= beat_d;
        end
    end

    dump_axis_packer_axis_out_reg u_out (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .data_i   (load_data),
        .last_i   (load_last),
        .tready_i (i_m_axis_k2h_tready),
        .valid_o  (out_valid),
        .data_o   (o_m_axis_k2h_tdata),
        .last_o   (o_m_axis_k2h_tlast),
        .free_o   (out_free)
    );

    assign o_entry_ready       = entry_ready;
    assign o_m_axis_k2h_tvalid = out_valid;
    assign o_m_axis_k2h_tkeep  = {KEEP_W{out_valid}};
    assign o_m_axis_k2h_tdest  = dest_q;
    assign o_rec_count         = rec_q;
    assign o_beat_count        = beat_q;
    assign o_busy              = (state_q != IDLE);

endmodule

// File: doc/dump_axis_packer.md
Name: dump_axis_packer

Overview:
Downstream consumer of the pair exit FIFO during a dump. Each 227-bit exit-queue entry carries two 97-bit particle records plus two lane-valid bits. The block discards the invalid lanes and packs the valid records densely, five per 512-bit beat. It drives the k2h AXI4-Stream toward the host with full tready backpressure, tdest, and a terminating tlast beat.

Parameters:
REC_WIDTH, 97, bits per particle record
RECS_PER_BEAT, 5, record slots per output beat (5*97=485 <= 512)
AXIS_TDATA_WIDTH, 512, output stream data width
STREAMING_TDEST_WIDTH, 16, tdest width
IN_WIDTH, 227, exit-queue entry width
CNT_WIDTH, 32, width of record/beat counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_dump_start  in  1  one-cycle pulse that begins a dump
i_dump_flush  in  1  one-cycle pulse: no more entries, so emit the final beat
i_dest_id  in  STREAMING_TDEST_WIDTH  tdest, latched at i_dump_start
i_entry  in  IN_WIDTH  [96:0] lane0 record, [193:97] lane1 record, [195:194] lane valids {v1,v0}, [226:196] ignored
i_entry_valid  in  1  entry present
o_entry_ready  out  1  entry accepted when valid&&ready
o_m_axis_k2h_tdata  out  AXIS_TDATA_WIDTH  slot k at [97k+96:97k]; [508:485] zero; [511:509] record count 0..5
o_m_axis_k2h_tkeep  out  AXIS_TDATA_WIDTH/8  all ones whenever tvalid
o_m_axis_k2h_tvalid  out  1  beat valid
o_m_axis_k2h_tlast  out  1  final beat of dump
o_m_axis_k2h_tdest  out  STREAMING_TDEST_WIDTH  latched dest id
i_m_axis_k2h_tready  in  1  host ready
o_rec_count  out  CNT_WIDTH  valid records accepted this dump
o_beat_count  out  CNT_WIDTH  beats transferred (valid&&ready) this dump
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0 except tkeep, which is 0 while tvalid=0. Accumulator empty, counters 0.
- States:
  - IDLE: i_dump_start goes to RUN; latch tdest; clear counters and accumulator.
  - RUN: i_dump_flush goes to FLUSH.
  - FLUSH: terminating beat is loaded into the output register once it is free, then go to LAST.
  - LAST: the tlast beat transfers (tvalid&&tready), then go to IDLE.
- i_dump_start outside IDLE is ignored.
- o_entry_ready = (state==RUN) && (acc_cnt<=3 || !out_valid || tready). Entries are never accepted in IDLE, FLUSH or LAST.
- Packing order: lane0 before lane1, slots filled ascending from 0. An entry with valids 2'b00 is accepted and contributes nothing. Valids 2'b10 places lane1 in the next free slot.
- When acc_cnt+n reaches 5, the full beat moves to the output register, count=5, tlast=0. Any overflow record (acc_cnt=4, n=2) becomes slot 0 of the new accumulator.
- Latency: the entry that completes a beat is accepted at cycle N; tvalid is asserted at N+1.
- Output register: single stage. It loads when empty or when the current beat transfers in the same cycle, giving zero-bubble streaming.
- tdata, tlast and tdest hold stable while tvalid && !tready.
- Terminating beat:
  - Accumulator non-empty: the partial beat, count = acc_cnt, unused slots zero, tlast=1.
  - Accumulator empty: a zero-data beat, count=0, tlast=1.
  - Exactly one tlast beat per dump.
- i_dump_flush in the same cycle as an accepted entry: the entry is packed first, then the flush applies.
- Counters wrap modulo 2^CNT_WIDTH. o_rec_count adds n per accepted entry. o_beat_count increments per transfer, including the tlast beat.
- rst mid-dump: immediate return to IDLE. The in-flight beat is dropped and tvalid deasserts asynchronously.

Decomposition:
- Shared package: REC_WIDTH, RECS_PER_BEAT, entry field offsets (LANE0_LSB, LANE1_LSB, VALID_LSB), beat count field position [511:509], and the state enum {IDLE, RUN, FLUSH, LAST}.
- One natural sub-module: axis_out_reg, the single-entry output register with tvalid/tready hold semantics.

Test Plan:
- Start with dest=0x0007, then 5 entries each with valids=2'b11 (10 records), then flush. Required: two count=5 beats, then one count=0 tlast beat. tdest=0x0007. o_rec_count=10, o_beat_count=3.
- Entries with valids 01,10,00,11 (4 records), then flush. Required: one beat, count=4; slot0=lane0(e0), slot1=lane1(e1), slot2/3 from e3; tlast=1.
- Accumulator holds 4, then an 11 entry arrives. Required: beat carries slots 0-4 with count=5; the leftover lane1 record is in slot 0 of the next beat.
- Hold tready=0 for 20 cycles with a full output register and acc_cnt=4. Required: o_entry_ready=0, tdata stable throughout; no record lost or duplicated after release.
- Flush in the same cycle as an accepted 11 entry with acc_cnt=3. Required: one count=5 beat, then a count=0 tlast beat.
- Assert rst while tvalid=1 during RUN. Required: tvalid=0 and o_busy=0 immediately. The next dump starts with counters at 0.
